// File: rtl/gbp_update_scheduler.sv
// Arbitrates the single gbp counter-table port between frontend lookups, an init sweep
// and queued read-modify-write updates from resolved branches.
module gbp_update_scheduler #(
  parameter int NR_ENTRIES  = 1024,
  parameter int INDEX_W     = $clog2(NR_ENTRIES),
  parameter int QUEUE_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               lookup_valid_i,
  input  logic [INDEX_W-1:0] lookup_index_i,
  output logic               lookup_rvalid_o,
  output logic [1:0]         lookup_ctr_o,
  input  logic               upd_valid_i,
  output logic               upd_ready_o,
  input  logic [INDEX_W-1:0] upd_index_i,
  input  logic               upd_taken_i,
  output logic               busy_o,
  output logic               tbl_req_o,
  output logic               tbl_we_o,
  output logic [INDEX_W-1:0] tbl_addr_o,
  output logic [1:0]         tbl_wdata_o,
  input  logic [1:0]         tbl_rdata_i
);

  localparam int QPTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W  = QPTR_W + 1;
  localparam logic [INDEX_W-1:0] LAST_ROW = INDEX_W'(NR_ENTRIES - 1);
  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(QUEUE_DEPTH);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_UPD_READ, ST_UPD_WRITE} state_e;

  state_e               state_q, state_d;
  logic [INDEX_W-1:0]   ptr_q, ptr_d;
  logic [QPTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [INDEX_W-1:0]   cur_index_q, cur_index_d;
  logic                 cur_taken_q, cur_taken_d;
  logic [1:0]           ctr_q, ctr_d;
  logic                 first_q, first_d;
  logic                 lookup_rvalid_q, lookup_rvalid_d;
  logic                 lookup_init_q, lookup_init_d;
  logic [INDEX_W-1:0]   q_index_mem [QUEUE_DEPTH];
  logic                 q_taken_mem [QUEUE_DEPTH];

  logic                 full, empty, push, pop;
  logic                 req, we;
  logic [INDEX_W-1:0]   addr;
  logic [1:0]           wdata, ctr_cur;

  function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
  endfunction

  assign full        = (count_q == FULL_CNT);
  assign empty       = (count_q == '0);
  assign upd_ready_o = rst_ni && !full && !flush_i;
  assign push        = upd_valid_i && upd_ready_o;
  // Read data is only live in the first write cycle; a stalled write reuses the copy.
  assign ctr_cur     = first_q ? tbl_rdata_i : ctr_q;

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    cur_index_d     = cur_index_q;
    cur_taken_d     = cur_taken_q;
    ctr_d           = ctr_q;
    first_d         = 1'b0;
    pop             = 1'b0;
    req             = 1'b0;
    we              = 1'b0;
    addr            = '0;
    wdata           = 2'b00;
    lookup_rvalid_d = lookup_valid_i;
    lookup_init_d   = lookup_valid_i && (flush_i || state_q == ST_INIT);

    if (flush_i) begin
      state_d  = ST_INIT;
      ptr_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (state_q == ST_INIT) begin
        req   = 1'b1;
        we    = 1'b1;
        addr  = ptr_q;
        wdata = 2'b01;
        ptr_d = ptr_q + INDEX_W'(1);
        if (ptr_q == LAST_ROW) state_d = ST_IDLE;
      end else begin
        if (lookup_valid_i) begin
          req  = 1'b1;
          addr = lookup_index_i;
        end
        if (state_q == ST_IDLE) begin
          if (!empty) state_d = ST_UPD_READ;
        end else if (state_q == ST_UPD_READ) begin
          if (!lookup_valid_i) begin
            req         = 1'b1;
            addr        = q_index_mem[rd_ptr_q];
            pop         = 1'b1;
            cur_index_d = q_index_mem[rd_ptr_q];
            cur_taken_d = q_taken_mem[rd_ptr_q];
            first_d     = 1'b1;
            state_d     = ST_UPD_WRITE;
          end
        end else begin
          ctr_d = ctr_cur;
          if (!lookup_valid_i) begin
            req     = 1'b1;
            we      = 1'b1;
            addr    = cur_index_q;
            wdata   = sat_ctr(ctr_cur, cur_taken_q);
            state_d = (!empty || push) ? ST_UPD_READ : ST_IDLE;
          end
        end
      end
      if (push) wr_ptr_d = wr_ptr_q + QPTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + QPTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= ST_INIT;
      ptr_q           <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      cur_index_q     <= '0;
      cur_taken_q     <= 1'b0;
      ctr_q           <= 2'b00;
      first_q         <= 1'b0;
      lookup_rvalid_q <= 1'b0;
      lookup_init_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      cur_index_q     <= cur_index_d;
      cur_taken_q     <= cur_taken_d;
      ctr_q           <= ctr_d;
      first_q         <= first_d;
      lookup_rvalid_q <= lookup_rvalid_d;
      lookup_init_q   <= lookup_init_d;
    end
  end

  // Queue payload needs no reset; occupancy is tracked by the pointers and count.
  for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_queue
    always_ff @(posedge clk_i) begin
      if (push && wr_ptr_q == QPTR_W'(gi)) begin
        q_index_mem[gi] <= upd_index_i;
        q_taken_mem[gi] <= upd_taken_i;
      end
    end
  end

  assign busy_o          = (state_q == ST_INIT);
  assign lookup_rvalid_o = lookup_rvalid_q;
  assign lookup_ctr_o    = lookup_rvalid_q ? (lookup_init_q ? 2'b01 : tbl_rdata_i) : 2'b00;
  assign tbl_req_o       = rst_ni && req;
  assign tbl_we_o        = rst_ni && we;
  assign tbl_addr_o      = rst_ni ? addr : '0;
  assign tbl_wdata_o     = rst_ni ? wdata : 2'b00;

endmodule
